// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    AND = 3'd0,
    ADD = 3'd1,
    XOR = 3'd2,
    SUB = 3'd3,
    LSL = 3'd4,
    LSR = 3'd5,
    OR  = 3'd6,
    ADC = 3'd7
  } alu_op_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result/flag bundle between the register-file read ports, the ALU and writeback.
interface alu_if import alu_pkg::*; #(parameter int W = DATA_W);

  logic [2:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic [W-1:0] inC;
  logic [W-1:0] rslt;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         parity;

  modport master (
    output alu_cmd, inA, inB, inC,
    input  rslt, carry, zero, neg, parity
  );

  modport slave (
    input  alu_cmd, inA, inB, inC,
    output rslt, carry, zero, neg, parity
  );

endinterface

// File: rtl/alu_shifter.sv
// Logical barrel shifter with shifted-out bit; amount 0 passes through, amounts above W flush to zero.
module alu_shifter import alu_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] amount,
  input  logic         direction,
  output logic [W-1:0] shifted,
  output logic         shift_out
);

  localparam logic [W-1:0] AMT_MAX = W'(W);

  // One guard bit beyond the data catches the last bit pushed out, which also covers amount == W.
  always_comb begin
    shifted   = '0;
    shift_out = 1'b0;
    if (amount == '0) begin
      shifted = value;
    end else if (amount <= AMT_MAX) begin
      if (direction) begin
        {shifted, shift_out} = {value, 1'b0} >> amount;
      end else begin
        {shift_out, shifted} = {1'b0, value} << amount;
      end
    end
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational result plus registered carry/zero/neg flags.
// Define ALU_PARITY_EN to add the registered even-parity flag; otherwise parity is tied to 0.
module alu import alu_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  alu_op_t      op;
  logic         cin;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic [W-1:0] sh_res;
  logic         sh_out;
  logic [W-1:0] result;
  logic         next_carry;
  logic         carry_q;
  logic         zero_q;
  logic         neg_q;
  logic         unused_inc;

  assign op         = alu_op_t'(bus.alu_cmd);
  assign cin        = (op == ADC) & bus.inC[0];
  assign unused_inc = ^bus.inC[W-1:1];

  // Bit W of the widened difference is the borrow for inB - inA.
  assign sum_ext  = {1'b0, bus.inA} + {1'b0, bus.inB} + {{W{1'b0}}, cin};
  assign diff_ext = {1'b0, bus.inB} - {1'b0, bus.inA};

  alu_shifter #(.W(W)) u_shifter (
    .value     (bus.inB),
    .amount    (bus.inA),
    .direction (op == LSR),
    .shifted   (sh_res),
    .shift_out (sh_out)
  );

  always_comb begin
    result     = '0;
    next_carry = 1'b0;
    case (op)
      AND: result = bus.inA & bus.inB;
      XOR: result = bus.inA ^ bus.inB;
      OR:  result = bus.inA | bus.inB;
      ADD, ADC: begin
        result     = sum_ext[W-1:0];
        next_carry = sum_ext[W];
      end
      SUB: begin
        result     = diff_ext[W-1:0];
        next_carry = diff_ext[W];
      end
      LSL, LSR: begin
        result     = sh_res;
        next_carry = sh_out;
      end
      default: ;
    endcase
  end

  assign bus.rslt = result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      carry_q <= next_carry;
      zero_q  <= (result == '0);
      neg_q   <= result[W-1];
    end
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.neg   = neg_q;

`ifdef ALU_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^result;
    end
  end

  assign bus.parity = parity_q;
`else
  assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors then random vectors against an arithmetic reference.
module tb_alu;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_if #(.W(DATA_W)) bus ();

  alu #(.W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    int         cyc;
    logic [7:0] r;
    logic       cy;
    logic       z;
    logic       n;
    logic       p;
  } exp_t;

  exp_t rslt_q[$];
  exp_t flag_q[$];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Arithmetic reference, written with integer math rather than bit slicing of the datapath.
  function automatic void refModel(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c, output logic [7:0] r, output logic cy);
    int s;
    r  = 8'h00;
    cy = 1'b0;
    case (cmd)
      3'd0: r = a & b;
      3'd2: r = a ^ b;
      3'd6: r = a | b;
      3'd1, 3'd7: begin
        s  = int'(a) + int'(b) + ((cmd == 3'd7) ? int'(c[0]) : 0);
        r  = s[7:0];
        cy = (s > 255);
      end
      3'd3: begin
        s  = int'(b) - int'(a);
        r  = s[7:0];
        cy = (b < a);
      end
      3'd4: begin
        if (a == 0) r = b;
        else if (a <= 8) begin
          s  = int'(b) * (1 << a);
          r  = s[7:0];
          cy = s[8];
        end
      end
      default: begin
        if (a == 0) r = b;
        else if (a <= 8) begin
          s  = int'(b) / (1 << a);
          r  = s[7:0];
          s  = int'(b) / (1 << (a - 1));
          cy = s[0];
        end
      end
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic rst_n, input logic [2:0] cmd,
                               input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic [7:0] er, input logic ecy, input logic ez, input logic en);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst_n;
    bus.alu_cmd = cmd;
    bus.inA     = a;
    bus.inB     = b;
    bus.inC     = c;
    e.tag = tag;
    e.cyc = cyc;
    e.r   = er;
    e.cy  = rst_n & ecy;
    e.z   = rst_n & ez;
    e.n   = rst_n & en;
`ifdef ALU_PARITY_EN
    e.p   = rst_n & (^er);
`else
    e.p   = 1'b0;
`endif
    rslt_q.push_back(e);
    flag_q.push_back(e);
  endtask

  // Result is checked in its issue cycle; flags one edge later.
  always @(negedge clk) begin
    exp_t e;
    while (rslt_q.size() > 0 && rslt_q[0].cyc == cyc) begin
      e = rslt_q.pop_front();
      checkOutput({e.tag, ".rslt"}, bus.rslt, e.r);
    end
    while (flag_q.size() > 0 && flag_q[0].cyc + 1 == cyc) begin
      e = flag_q.pop_front();
      checkOutput({e.tag, ".carry"},  {7'b0, bus.carry},  {7'b0, e.cy});
      checkOutput({e.tag, ".zero"},   {7'b0, bus.zero},   {7'b0, e.z});
      checkOutput({e.tag, ".neg"},    {7'b0, bus.neg},    {7'b0, e.n});
      checkOutput({e.tag, ".parity"}, {7'b0, bus.parity}, {7'b0, e.p});
    end
  end

  initial begin
    logic [2:0] cmd;
    logic [7:0] a, b, c, r;
    logic       cy;

    bus.alu_cmd = 3'd0;
    bus.inA     = 8'h00;
    bus.inB     = 8'h00;
    bus.inC     = 8'h00;
    repeat (2) @(posedge clk);

    applyStimulus("rst_hold",  1'b0, 3'd1, 8'd7,   8'd9,   8'h00, 8'd16,  1'b0, 1'b0, 1'b0);
    applyStimulus("chain_add", 1'b1, 3'd1, 8'd1,   8'd0,   8'h00, 8'd1,   1'b0, 1'b0, 1'b0);
    applyStimulus("chain_lsl", 1'b1, 3'd4, 8'd3,   8'd1,   8'h00, 8'd8,   1'b0, 1'b0, 1'b0);
    applyStimulus("chain_lsr", 1'b1, 3'd5, 8'd1,   8'd8,   8'h00, 8'd4,   1'b0, 1'b0, 1'b0);
    applyStimulus("chain_and", 1'b1, 3'd0, 8'd128, 8'd4,   8'h00, 8'd0,   1'b0, 1'b1, 1'b0);
    applyStimulus("chain_xor", 1'b1, 3'd2, 8'd255, 8'd170, 8'h00, 8'd85,  1'b0, 1'b0, 1'b0);
    applyStimulus("add_cy",    1'b1, 3'd1, 8'd200, 8'd100, 8'h00, 8'd44,  1'b1, 1'b0, 1'b0);
    applyStimulus("adc_cy",    1'b1, 3'd7, 8'd255, 8'd0,   8'h01, 8'd0,   1'b1, 1'b1, 1'b0);
    applyStimulus("adc_c0",    1'b1, 3'd7, 8'd1,   8'd1,   8'hFE, 8'd2,   1'b0, 1'b0, 1'b0);
    applyStimulus("add_noc",   1'b1, 3'd1, 8'd1,   8'd1,   8'h01, 8'd2,   1'b0, 1'b0, 1'b0);
    applyStimulus("sub_brw",   1'b1, 3'd3, 8'd5,   8'd3,   8'h00, 8'd254, 1'b1, 1'b0, 1'b1);
    applyStimulus("sub_ok",    1'b1, 3'd3, 8'd3,   8'd5,   8'h00, 8'd2,   1'b0, 1'b0, 1'b0);
    applyStimulus("lsl_8",     1'b1, 3'd4, 8'd8,   8'h01,  8'h00, 8'h00,  1'b1, 1'b1, 1'b0);
    applyStimulus("lsr_8",     1'b1, 3'd5, 8'd8,   8'h80,  8'h00, 8'h00,  1'b1, 1'b1, 1'b0);
    applyStimulus("lsr_9",     1'b1, 3'd5, 8'd9,   8'hFF,  8'h00, 8'h00,  1'b0, 1'b1, 1'b0);
    applyStimulus("lsl_0",     1'b1, 3'd4, 8'd0,   8'h81,  8'h00, 8'h81,  1'b0, 1'b0, 1'b1);
    applyStimulus("lsr_1",     1'b1, 3'd5, 8'd1,   8'h81,  8'h00, 8'h40,  1'b1, 1'b0, 1'b0);
    applyStimulus("rst_prio",  1'b0, 3'd1, 8'd255, 8'd1,   8'h00, 8'd0,   1'b1, 1'b1, 1'b0);
    applyStimulus("rst_rel",   1'b1, 3'd1, 8'd255, 8'd1,   8'h00, 8'd0,   1'b1, 1'b1, 1'b0);
    applyStimulus("or_par",    1'b1, 3'd6, 8'h07,  8'h00,  8'h00, 8'h07,  1'b0, 1'b0, 1'b0);
    applyStimulus("or_even",   1'b1, 3'd6, 8'h30,  8'h03,  8'h00, 8'h33,  1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      cmd = 3'($urandom_range(0, 7));
      a   = 8'($urandom);
      b   = 8'($urandom);
      c   = 8'($urandom);
      if ((cmd == 3'd4 || cmd == 3'd5) && $urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 10));
      refModel(cmd, a, b, c, r, cy);
      applyStimulus("rand", 1'b1, cmd, a, b, c, r, cy, (r == 8'h00), r[7]);
    end

    @(posedge clk);
    repeat (3) @(negedge clk);
    checkOutput("queue_drain", 8'(rslt_q.size() + flag_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
